cache_ctrl_wb: RTL and testbench

Write-back, write-allocate cache controller with multi-word line bursts; successor to the single-word write-through controller. Sits between the core's load/store stage and the memory interface. Drives the tag/data array control strobes and a beat-by-beat memory handshake. Stalls the core for the duration of every victim write-back and line refill.

---
 rtl/cache_pkg.sv | 31 +++
 rtl/cache_burst_cnt.sv | 42 ++++
 rtl/cache_ctrl_wb.sv | 203 ++++++++++++++++++++
 tb/tb_cache_ctrl_wb.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the write-back cache controller: FSM state type,
// default geometry, derived widths and the perf counter helper.
// Optional feature macro: CACHE_PERF_CNT_EN (adds saturating perf counters).
package cache_pkg;

  // Default geometry; the controller exposes these as overridable parameters.
  localparam int unsigned LineWordsDef = 4;
  localparam int unsigned WordWDef     = 32;
  localparam int unsigned AddrWDef     = 32;
  localparam int unsigned IdxWDef      = 5;

  // Derived widths for the default geometry.
  localparam int unsigned OFF_W = $clog2(LineWordsDef);
  localparam int unsigned TAG_W = AddrWDef - IdxWDef - OFF_W - 2;

  // Width of each performance counter.
  localparam int unsigned PERF_W = 32;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWb     = 2'd1,
    StRefill = 2'd2,
    StDone   = 2'd3
  } cache_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (v == {PERF_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cache_burst_cnt.sv
// Beat counter for line bursts. Wraps modulo LINE_WORDS; clr has priority.
module cache_burst_cnt
  import cache_pkg::*;
#(
  parameter int unsigned LINE_WORDS = LineWordsDef,
  localparam int unsigned OffW = $clog2(LINE_WORDS)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            inc_i,
  input  logic            clr_i,
  output logic [OffW-1:0] cnt_o,
  output logic            last_o
);

  localparam logic [OffW-1:0] LastCnt = OffW'(LINE_WORDS - 1);

  logic [OffW-1:0] cnt_q, cnt_d;

  // Next count: clear beats increment, natural wrap at LINE_WORDS.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == LastCnt);

endmodule

// File: rtl/cache_ctrl_wb.sv
// Write-back, write-allocate cache controller with multi-word line bursts.
// Misses stall the core through an optional victim write-back and a refill.
// Optional feature macro: CACHE_PERF_CNT_EN (hit/miss/write-back counters).
module cache_ctrl_wb
  import cache_pkg::*;
#(
  parameter int unsigned LINE_WORDS = LineWordsDef,
  parameter int unsigned WORD_W     = WordWDef,
  parameter int unsigned ADDR_W     = AddrWDef,
  parameter int unsigned IDX_W      = IdxWDef,
  localparam int unsigned OffW = $clog2(LINE_WORDS),
  localparam int unsigned TagW = ADDR_W - IDX_W - OffW - 2,
  localparam int unsigned LaW  = ADDR_W - OffW - 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rd_en_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              hit_i,
  input  logic              dirty_i,
  input  logic [TagW-1:0]   victim_tag_i,
  input  logic              mem_ack_i,
  output logic              stall_o,
  output logic              update_o,
  output logic              set_dirty_o,
  output logic              wb_rd_o,
  output logic              refill_we_o,
  output logic              tag_we_o,
  output logic [OffW-1:0]   beat_idx_o,
  output logic [LaW-1:0]    line_addr_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
`ifdef CACHE_PERF_CNT_EN
  output logic [PERF_W-1:0] hit_cnt_o,
  output logic [PERF_W-1:0] miss_cnt_o,
  output logic [PERF_W-1:0] wb_cnt_o,
`endif
  output logic [ADDR_W-1:0] mem_addr_o
);

  // Beat addresses are word aligned with a 2-bit byte offset, so words are 32 bits.
  if (WORD_W != 32) begin : gen_bad_word_w
    $error("cache_ctrl_wb: WORD_W must be 32");
  end
  if ((LINE_WORDS < 2) || ((LINE_WORDS & (LINE_WORDS - 1)) != 0)) begin : gen_bad_line
    $error("cache_ctrl_wb: LINE_WORDS must be a power of two >= 2");
  end

  cache_state_e    state_q;
  logic [LaW-1:0]  line_addr_q;
  logic [TagW-1:0] victim_tag_q;
  logic            op_wr_q;
  logic            mem_req_q;
  logic            mem_we_q;
  logic            wb_rd_q;

  logic            access;
  logic            miss;
  logic            beat_ack;
  logic            beat_last;
  logic            cnt_clr;
  logic [OffW-1:0] beat_idx;

  // Byte offset and word offset never select anything here.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addr_i[OffW+1:0];

  assign access   = rd_en_i | wr_en_i;
  assign miss     = (state_q == StIdle) && access && !hit_i;
  // Acks only matter while a beat request is outstanding.
  assign beat_ack = mem_req_q & mem_ack_i;
  assign cnt_clr  = (state_q == StIdle);

  cache_burst_cnt #(
    .LINE_WORDS (LINE_WORDS)
  ) u_burst_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (beat_ack),
    .clr_i  (cnt_clr),
    .cnt_o  (beat_idx),
    .last_o (beat_last)
  );

  // Controller FSM with registered memory-side strobes and miss context.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      line_addr_q  <= '0;
      victim_tag_q <= '0;
      op_wr_q      <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      wb_rd_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (miss) begin
            line_addr_q <= addr_i[ADDR_W-1:OffW+2];
            op_wr_q     <= wr_en_i;
            mem_req_q   <= 1'b1;
            if (dirty_i) begin
              victim_tag_q <= victim_tag_i;
              mem_we_q     <= 1'b1;
              wb_rd_q      <= 1'b1;
              state_q      <= StWb;
            end else begin
              mem_we_q <= 1'b0;
              wb_rd_q  <= 1'b0;
              state_q  <= StRefill;
            end
          end
        end
        StWb: begin
          if (beat_ack && beat_last) begin
            mem_we_q <= 1'b0;
            wb_rd_q  <= 1'b0;
            state_q  <= StRefill;
          end
        end
        StRefill: begin
          if (beat_ack && beat_last) begin
            mem_req_q <= 1'b0;
            state_q   <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Core-side strobes and beat address decode.
  always_comb begin
    stall_o     = 1'b0;
    update_o    = 1'b0;
    set_dirty_o = 1'b0;
    refill_we_o = 1'b0;
    tag_we_o    = 1'b0;
    mem_addr_o  = '0;
    unique case (state_q)
      StIdle: begin
        if (access && hit_i && wr_en_i) begin
          update_o    = 1'b1;
          set_dirty_o = 1'b1;
        end
        stall_o = miss;
      end
      StWb: begin
        stall_o    = 1'b1;
        mem_addr_o = {victim_tag_q, line_addr_q[IDX_W-1:0], beat_idx, 2'b00};
      end
      StRefill: begin
        stall_o     = 1'b1;
        mem_addr_o  = {line_addr_q, beat_idx, 2'b00};
        refill_we_o = beat_ack;
        tag_we_o    = beat_ack & beat_last;
      end
      StDone: begin
        stall_o     = 1'b1;
        update_o    = op_wr_q;
        set_dirty_o = op_wr_q;
      end
      default: ;
    endcase
  end

  assign beat_idx_o  = beat_idx;
  assign line_addr_o = line_addr_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign wb_rd_o     = wb_rd_q;

`ifdef CACHE_PERF_CNT_EN
  logic [PERF_W-1:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;

  // Saturating event counters; every access seen in IDLE is either a hit or a miss.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else if (state_q == StIdle && access) begin
      if (hit_i) begin
        hit_cnt_q <= sat_inc(hit_cnt_q);
      end else begin
        miss_cnt_q <= sat_inc(miss_cnt_q);
        if (dirty_i) begin
          wb_cnt_q <= sat_inc(wb_cnt_q);
        end
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
  assign wb_cnt_o   = wb_cnt_q;
`endif

endmodule

// File: tb/tb_cache_ctrl_wb.sv
// Self-checking bench for cache_ctrl_wb: a memory responder with programmable
// wait states checks each beat against a queue of expected beat addresses.
module tb_cache_ctrl_wb;

  localparam int unsigned LW     = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned OFF_W  = 2;
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W - 2;
  localparam int unsigned LA_W   = ADDR_W - OFF_W - 2;

  logic              clk;
  logic              rst_n;
  logic              rd_en, wr_en, hit, dirty, mem_ack;
  logic [ADDR_W-1:0] addr;
  logic [TAG_W-1:0]  victim_tag;
  logic              stall, update, set_dirty, wb_rd, refill_we, tag_we, mem_req, mem_we;
  logic [OFF_W-1:0]  beat_idx;
  logic [LA_W-1:0]   line_addr;
  logic [ADDR_W-1:0] mem_addr;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0]       hit_cnt, miss_cnt, wb_cnt;
`endif

  logic [8+OFF_W+LA_W+ADDR_W-1:0] outs;
  assign outs = {stall, update, set_dirty, wb_rd, refill_we, tag_we, mem_req, mem_we,
                 beat_idx, line_addr, mem_addr};

  cache_ctrl_wb dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .rd_en_i      (rd_en),
    .wr_en_i      (wr_en),
    .addr_i       (addr),
    .hit_i        (hit),
    .dirty_i      (dirty),
    .victim_tag_i (victim_tag),
    .mem_ack_i    (mem_ack),
    .stall_o      (stall),
    .update_o     (update),
    .set_dirty_o  (set_dirty),
    .wb_rd_o      (wb_rd),
    .refill_we_o  (refill_we),
    .tag_we_o     (tag_we),
    .beat_idx_o   (beat_idx),
    .line_addr_o  (line_addr),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
`ifdef CACHE_PERF_CNT_EN
    .hit_cnt_o    (hit_cnt),
    .miss_cnt_o   (miss_cnt),
    .wb_cnt_o     (wb_cnt),
`endif
    .mem_addr_o   (mem_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
  } beat_t;

  beat_t             exp_q[$];
  int                checks = 0;
  int                errors = 0;
  int                wait_cycles = 0;
  int                wait_cnt = 0;
  int                stall_cnt = 0;
  int                tag_we_cnt = 0;
  int                upd_stall_cnt = 0;
  logic              pend = 1'b0;
  logic [ADDR_W-1:0] pend_addr;
  logic              pend_we;

  // Memory responder and beat monitor: ack after wait_cycles, check on the next ns.
  always begin
    @(negedge clk);
    if (!rst_n) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
      pend     = 1'b0;
    end else begin
      if (mem_req) begin
        if (wait_cnt >= wait_cycles) begin
          mem_ack  = 1'b1;
          wait_cnt = 0;
        end else begin
          mem_ack  = 1'b0;
          wait_cnt = wait_cnt + 1;
        end
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end
      #1;
      if (stall) stall_cnt = stall_cnt + 1;
      if (tag_we) tag_we_cnt = tag_we_cnt + 1;
      if (update && stall) upd_stall_cnt = upd_stall_cnt + 1;
      if (!stall) begin
        checks = checks + 1;
        if (beat_idx !== '0) begin
          errors = errors + 1;
          $display("FAIL idle_beat_idx: got %0d want 0", beat_idx);
        end
      end
      if (mem_req && pend) begin
        checks = checks + 1;
        if (mem_addr !== pend_addr || mem_we !== pend_we) begin
          errors = errors + 1;
          $display("FAIL req_hold: got %h/%b want %h/%b", mem_addr, mem_we, pend_addr, pend_we);
        end
      end
      if (mem_req && mem_ack) begin
        beat_t e;
        checks = checks + 1;
        if (exp_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL beat_unexpected: got addr %h we %b want none", mem_addr, mem_we);
        end else begin
          e = exp_q.pop_front();
          if (mem_addr !== e.addr || mem_we !== e.we || wb_rd !== e.we ||
              refill_we !== !e.we || tag_we !== (!e.we && exp_q.size() == 0)) begin
            errors = errors + 1;
            $display("FAIL beat: got addr %h we %b wb_rd %b rwe %b twe %b want addr %h we %b",
                     mem_addr, mem_we, wb_rd, refill_we, tag_we, e.addr, e.we);
          end
        end
      end
      pend      = mem_req && !mem_ack;
      pend_addr = mem_addr;
      pend_we   = mem_we;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic clear_counts();
    stall_cnt     = 0;
    tag_we_cnt    = 0;
    upd_stall_cnt = 0;
  endtask

  // Issue one missing access, push its expected beats, and wait for the stall to end.
  task automatic miss_access(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                             input logic d, input logic [TAG_W-1:0] vt, input int waits);
    logic [ADDR_W-1:0] wb_base, rf_base;
    int n;
    wb_base = {vt, a[IDX_W+OFF_W+1:OFF_W+2], {(OFF_W+2){1'b0}}};
    rf_base = {a[ADDR_W-1:OFF_W+2], {(OFF_W+2){1'b0}}};
    @(posedge clk);
    #1;
    wait_cycles = waits;
    clear_counts();
    if (d) for (int i = 0; i < LW; i++) exp_q.push_back('{addr: wb_base + 4 * i, we: 1'b1});
    for (int i = 0; i < LW; i++) exp_q.push_back('{addr: rf_base + 4 * i, we: 1'b0});
    rd_en = rd; wr_en = wr; addr = a; hit = 1'b0; dirty = d; victim_tag = vt;
    @(posedge clk);
    #1;
    rd_en = 1'b0; wr_en = 1'b0; hit = 1'b0; dirty = 1'b0; victim_tag = '0; addr = '0;
    n = 0;
    while (n < 500) begin
      @(negedge clk);
      #2;
      if (!stall) break;
      n++;
    end
    checks = checks + 1;
    if (n >= 500) begin
      errors = errors + 1;
      $display("FAIL miss_timeout: got stall stuck want release");
    end
  endtask

  task automatic check_miss(input string name, input int want_stall, input int want_upd);
    checks = checks + 4;
    if (stall_cnt !== want_stall) begin
      errors = errors + 1;
      $display("FAIL %s_stall: got %0d want %0d", name, stall_cnt, want_stall);
    end
    if (tag_we_cnt !== 1) begin
      errors = errors + 1;
      $display("FAIL %s_tag_we: got %0d want 1", name, tag_we_cnt);
    end
    if (upd_stall_cnt !== want_upd) begin
      errors = errors + 1;
      $display("FAIL %s_done_update: got %0d want %0d", name, upd_stall_cnt, want_upd);
    end
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL %s_beats_left: got %0d want 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rd_en = 1'b0; wr_en = 1'b0; addr = '0; hit = 1'b0; dirty = 1'b0;
    victim_tag = '0; mem_ack = 1'b0;
    #12;
    checks = checks + 1;
    if (outs !== '0) begin
      errors = errors + 1;
      $display("FAIL reset_outputs: got %h want 0", outs);
    end
    @(negedge clk);
    #3 rst_n = 1'b1;
    #1;
    checks = checks + 1;
    if (outs !== '0) begin
      errors = errors + 1;
      $display("FAIL post_reset_outputs: got %h want 0", outs);
    end
  endtask

  task automatic test_hits();
    @(posedge clk);
    #1;
    rd_en = 1'b1; wr_en = 1'b0; addr = 32'h40; hit = 1'b1;
    #2;
    checks = checks + 1;
    if ({stall, update, set_dirty, mem_req} !== 4'b0000) begin
      errors = errors + 1;
      $display("FAIL read_hit: got %b want 0000", {stall, update, set_dirty, mem_req});
    end
    @(posedge clk);
    #1;
    rd_en = 1'b0; wr_en = 1'b1;
    #2;
    checks = checks + 1;
    if ({stall, update, set_dirty, mem_req} !== 4'b0110) begin
      errors = errors + 1;
      $display("FAIL write_hit: got %b want 0110", {stall, update, set_dirty, mem_req});
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0; hit = 1'b0; addr = '0;
    #2;
    checks = checks + 1;
    if ({stall, update, set_dirty, mem_req} !== 4'b0000) begin
      errors = errors + 1;
      $display("FAIL after_hits: got %b want 0000", {stall, update, set_dirty, mem_req});
    end
  endtask

  task automatic test_clean_read_miss();
    miss_access(1'b1, 1'b0, 32'h1230, 1'b0, '0, 0);
    check_miss("clean_rd", 6, 0);
  endtask

  task automatic test_dirty_write_miss();
    miss_access(1'b0, 1'b1, 32'h2250, 1'b1, 23'h5A, 2);
    check_miss("dirty_wr", 26, 1);
  endtask

  task automatic test_dirty_read_boundary();
    miss_access(1'b1, 1'b0, 32'hFFFF_FFF4, 1'b1, 23'h7F_FFFF, 1);
    check_miss("dirty_rd_top", 1 + 2 * LW * 2 + 1, 0);
  endtask

  task automatic test_rd_wr_miss();
    miss_access(1'b1, 1'b1, 32'h3370, 1'b0, 23'h11, 0);
    check_miss("rdwr", 6, 1);
  endtask

  task automatic test_reset_mid_refill();
    int n;
    @(posedge clk);
    #1;
    wait_cycles = 0;
    clear_counts();
    for (int i = 0; i < LW; i++) exp_q.push_back('{addr: 32'h1230 + 4 * i, we: 1'b0});
    rd_en = 1'b1; addr = 32'h1230; hit = 1'b0; dirty = 1'b0;
    @(posedge clk);
    #1;
    rd_en = 1'b0; addr = '0;
    n = 0;
    while (n < 50) begin
      if (beat_idx == 2'd2 && mem_req && !mem_we) break;
      @(posedge clk);
      #1;
      n++;
    end
    checks = checks + 1;
    if (n >= 50) begin
      errors = errors + 1;
      $display("FAIL mid_refill_reach: got beat %0d want 2", beat_idx);
    end
    rst_n = 1'b0;
    #1;
    checks = checks + 2;
    if (outs !== '0) begin
      errors = errors + 1;
      $display("FAIL mid_refill_reset: got %h want 0", outs);
    end
    if (tag_we_cnt !== 0) begin
      errors = errors + 1;
      $display("FAIL mid_refill_tag_we: got %0d want 0", tag_we_cnt);
    end
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    #3 rst_n = 1'b1;
    miss_access(1'b1, 1'b0, 32'h1230, 1'b0, '0, 0);
    check_miss("re_miss", 6, 0);
  endtask

`ifdef CACHE_PERF_CNT_EN
  task automatic test_perf_counters();
    rst_n = 1'b0;
    #3;
    @(negedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      rd_en = 1'b1; addr = 32'h80 + 4 * i; hit = 1'b1;
    end
    @(posedge clk);
    #1;
    rd_en = 1'b0; hit = 1'b0;
    miss_access(1'b1, 1'b0, 32'h500, 1'b0, '0, 0);
    miss_access(1'b0, 1'b1, 32'h600, 1'b1, 23'h33, 0);
    checks = checks + 1;
    if ({hit_cnt, miss_cnt, wb_cnt} !== {32'd3, 32'd2, 32'd1}) begin
      errors = errors + 1;
      $display("FAIL perf_cnt: got %0d/%0d/%0d want 3/2/1", hit_cnt, miss_cnt, wb_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_hits();
    test_clean_read_miss();
    test_dirty_write_miss();
    test_dirty_read_boundary();
    test_rd_wr_miss();
    test_reset_mid_refill();
`ifdef CACHE_PERF_CNT_EN
    test_perf_counters();
`endif
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
